// File: rtl/cpu_core.sv
// Multi-cycle 32-bit core for a subset of the ECE350 ISA.
// Runs FETCH -> EXEC -> FETCH; lw takes an extra MEM cycle to write back the RAM data.
module cpu_core (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000, OP_J    = 5'b00001, OP_BNE  = 5'b00010,
                         OP_JAL   = 5'b00011, OP_JR   = 5'b00100, OP_ADDI = 5'b00101,
                         OP_BLT   = 5'b00110, OP_SW   = 5'b00111, OP_LW   = 5'b01000,
                         OP_SETX  = 5'b10101, OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2,
                         ALU_OR  = 5'd3, ALU_SLL = 5'd4, ALU_SRA = 5'd5;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [4:0]  r_ir_rd;
  logic [31:0] r_mem_addr;

  logic [4:0]  w_op, w_rd, w_rs, w_rt, w_shamt, w_aluop;
  logic [31:0] w_imm, w_target, w_a, w_b;
  logic [31:0] w_add, w_sub, w_addi, w_sra, w_pc_inc, w_pc_br;
  logic        w_ovf_add, w_ovf_sub, w_ovf_addi;
  logic        w_we;
  logic [4:0]  w_wreg;
  logic [31:0] w_wdata;

  assign w_op     = q_imem[31:27];
  assign w_rd     = q_imem[26:22];
  assign w_rs     = q_imem[21:17];
  assign w_rt     = q_imem[16:12];
  assign w_shamt  = q_imem[11:7];
  assign w_aluop  = q_imem[6:2];
  assign w_imm    = {{15{q_imem[16]}}, q_imem[16:0]};
  assign w_target = {5'd0, q_imem[26:0]};

  assign w_a        = data_readRegA;
  assign w_b        = data_readRegB;
  assign w_add      = w_a + w_b;
  assign w_sub      = w_a - w_b;
  assign w_addi     = w_a + w_imm;
  assign w_sra      = $unsigned($signed(w_a) >>> w_shamt);
  assign w_pc_inc   = r_pc + 32'd1;
  assign w_pc_br    = w_pc_inc + w_imm;
  // Signed overflow: operands agree in sign (after negating b for sub) but the result does not.
  assign w_ovf_add  = (w_a[31] == w_b[31])   && (w_add[31]  != w_a[31]);
  assign w_ovf_sub  = (w_a[31] != w_b[31])   && (w_sub[31]  != w_a[31]);
  assign w_ovf_addi = (w_a[31] == w_imm[31]) && (w_addi[31] != w_a[31]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= '0;
      r_ir_rd    <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == S_EXEC) begin
        r_ir_rd    <= w_rd;
        r_mem_addr <= w_addi;
      end
    end
  end

  // Read indices depend only on state and the fetched word, keeping the regfile path loop-free.
  always_comb begin
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    if (r_state == S_EXEC) begin
      case (w_op)
        OP_RTYPE, OP_ADDI, OP_LW: begin ctrl_readRegA = w_rs; ctrl_readRegB = w_rt; end
        OP_SW:                    begin ctrl_readRegA = w_rs; ctrl_readRegB = w_rd; end
        OP_BNE, OP_BLT:           begin ctrl_readRegA = w_rd; ctrl_readRegB = w_rs; end
        OP_JR:                    ctrl_readRegA = w_rd;
        OP_BEX:                   ctrl_readRegA = 5'd30;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_we         = 1'b0;
    w_wreg       = '0;
    w_wdata      = '0;
    wren         = 1'b0;
    address_dmem = '0;
    data         = '0;
    case (r_state)
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC: begin
        w_state_next = S_FETCH;
        w_pc_next    = w_pc_inc;
        case (w_op)
          OP_RTYPE: begin
            w_we   = 1'b1;
            w_wreg = w_rd;
            case (w_aluop)
              ALU_ADD: if (w_ovf_add) begin w_wreg = 5'd30; w_wdata = 32'd1; end
                       else w_wdata = w_add;
              ALU_SUB: if (w_ovf_sub) begin w_wreg = 5'd30; w_wdata = 32'd3; end
                       else w_wdata = w_sub;
              ALU_AND: w_wdata = w_a & w_b;
              ALU_OR:  w_wdata = w_a | w_b;
              ALU_SLL: w_wdata = w_a << w_shamt;
              ALU_SRA: w_wdata = w_sra;
              default: w_we = 1'b0;
            endcase
          end
          OP_ADDI: begin
            w_we = 1'b1;
            if (w_ovf_addi) begin w_wreg = 5'd30; w_wdata = 32'd2; end
            else begin w_wreg = w_rd; w_wdata = w_addi; end
          end
          OP_SW: begin
            wren         = 1'b1;
            address_dmem = w_addi;
            data         = w_b;
          end
          OP_LW: begin
            address_dmem = w_addi;
            w_state_next = S_MEM;
            w_pc_next    = r_pc;
          end
          OP_J:   w_pc_next = w_target;
          OP_JAL: begin
            w_we      = 1'b1;
            w_wreg    = 5'd31;
            w_wdata   = w_pc_inc;
            w_pc_next = w_target;
          end
          OP_JR:   w_pc_next = w_a;
          OP_BNE:  if (w_a != w_b) w_pc_next = w_pc_br;
          OP_BLT:  if ($signed(w_a) < $signed(w_b)) w_pc_next = w_pc_br;
          OP_BEX:  if (w_a != 32'd0) w_pc_next = w_target;
          OP_SETX: begin
            w_we    = 1'b1;
            w_wreg  = 5'd30;
            w_wdata = w_target;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_state_next = S_FETCH;
        w_pc_next    = w_pc_inc;
        w_we         = 1'b1;
        w_wreg       = r_ir_rd;
        w_wdata      = q_dmem;
        address_dmem = r_mem_addr;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  assign address_imem     = r_pc;
  assign ctrl_writeEnable = w_we && (w_wreg != 5'd0);
  assign ctrl_writeReg    = w_wreg;
  assign data_writeReg    = w_wdata;
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: ROM/RAM/regfile models around the core and an
// instruction-level ISA interpreter that predicts writes, stores, timing and final state.
module tb_cpu_core;
  logic        clock, reset;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  cpu_core dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
  );

  typedef struct {int cyc; logic [31:0] a; logic [31:0] d;} ev_t;

  logic [31:0] rom [4096];
  logic [31:0] dram [4096];
  logic [31:0] rf [32];
  logic [31:0] init_mem [4096];
  logic [31:0] init_rf [32];
  logic [31:0] m_mem [4096];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc_final;
  logic [31:0] prog [$];
  ev_t exp_wr[$], exp_sw[$], dut_wr[$], dut_sw[$];
  int cyc;
  int n_cmp = 0;
  int n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

  // Synchronous ROM/RAM and regfile; while reset is held they reload from the init images.
  always @(posedge clock) begin
    q_imem <= rom[address_imem[11:0]];
    q_dmem <= dram[address_dmem[11:0]];
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_rf[i];
      for (int i = 0; i < 4096; i++) dram[i] <= init_mem[i];
    end else begin
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
      if (wren) dram[address_dmem[11:0]] <= data;
    end
  end

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      dut_wr.delete();
      dut_sw.delete();
    end else begin
      if (ctrl_writeEnable) dut_wr.push_back('{cyc, {27'd0, ctrl_writeReg}, data_writeReg});
      if (wren) dut_sw.push_back('{cyc, address_dmem, data});
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int alu, int rd, int rs, int rt, int sh);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(alu), 2'b00};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rd, int rs, int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int op, int t);
    return {5'(op), 27'(t)};
  endfunction

  function automatic int rreg();
    case ($urandom_range(0, 7))
      0: return 0;  1: return 1;  2: return 2;  3: return 30;  4: return 31;
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int imm;
    imm = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 16)) - 8;
    case ($urandom_range(0, 15))
      0, 1, 2, 3, 4: return enc_r($urandom_range(0, 7), rreg(), rreg(), rreg(), $urandom_range(0, 31));
      5:  return enc_i(5, rreg(), rreg(), imm);
      6:  return enc_i(7, rreg(), rreg(), imm);
      7:  return enc_i(8, rreg(), rreg(), imm);
      8:  return enc_j(1, $urandom);
      9:  return enc_j(3, $urandom);
      10: return enc_i(4, rreg(), 0, 0);
      11: return enc_i(2, rreg(), rreg(), imm);
      12: return enc_i(6, rreg(), rreg(), imm);
      13: return enc_j(22, $urandom);
      14: return enc_j(21, $urandom);
      default: return $urandom;
    endcase
  endfunction

  task automatic m_write(input int c, input int r, input logic [31:0] v);
    if (r != 0) begin
      m_regs[r] = v;
      exp_wr.push_back('{c, 32'(r), v});
    end
  endtask

  // ISA interpreter: one iteration per instruction; c is the cycle its fetch begins.
  task automatic model_run(input int n, output int total);
    int c, len;
    logic [31:0] pc, ir, a, b, imm, tgt, nxt;
    int op, rd, rs, rt, sh, alu;
    longint s;
    c = 0;
    pc = 0;
    for (int k = 0; k < n; k++) begin
      ir  = rom[pc[11:0]];
      op  = int'(ir[31:27]); rd = int'(ir[26:22]); rs = int'(ir[21:17]);
      rt  = int'(ir[16:12]); sh = int'(ir[11:7]);  alu = int'(ir[6:2]);
      imm = {{15{ir[16]}}, ir[16:0]};
      tgt = {5'd0, ir[26:0]};
      a = m_regs[rs];
      b = m_regs[rt];
      nxt = pc + 1;
      len = 2;
      case (op)
        0: case (alu)
             0: begin
               s = longint'($signed(a)) + longint'($signed(b));
               if (s > 64'sd2147483647 || s < -64'sd2147483648) m_write(c + 1, 30, 1);
               else m_write(c + 1, rd, a + b);
             end
             1: begin
               s = longint'($signed(a)) - longint'($signed(b));
               if (s > 64'sd2147483647 || s < -64'sd2147483648) m_write(c + 1, 30, 3);
               else m_write(c + 1, rd, a - b);
             end
             2: m_write(c + 1, rd, a & b);
             3: m_write(c + 1, rd, a | b);
             4: m_write(c + 1, rd, a << sh);
             5: m_write(c + 1, rd, 32'($signed(a) >>> sh));
             default: ;
           endcase
        5: begin
          s = longint'($signed(a)) + longint'($signed(imm));
          if (s > 64'sd2147483647 || s < -64'sd2147483648) m_write(c + 1, 30, 2);
          else m_write(c + 1, rd, a + imm);
        end
        7: begin
          a = a + imm;
          m_mem[a[11:0]] = m_regs[rd];
          exp_sw.push_back('{c + 1, a, m_regs[rd]});
        end
        8: begin
          a = a + imm;
          len = 3;
          m_write(c + 2, rd, m_mem[a[11:0]]);
        end
        1: nxt = tgt;
        3: begin m_write(c + 1, 31, pc + 1); nxt = tgt; end
        4: nxt = m_regs[rd];
        2: if (m_regs[rd] != m_regs[rs]) nxt = pc + 1 + imm;
        6: if ($signed(m_regs[rd]) < $signed(m_regs[rs])) nxt = pc + 1 + imm;
        22: if (m_regs[30] != 0) nxt = tgt;
        21: m_write(c + 1, 30, tgt);
        default: ;
      endcase
      c += len;
      pc = nxt;
    end
    total = c;
    m_pc_final = pc;
  endtask

  function automatic int last_wr_cyc(input int r);
    int res = -1;
    foreach (dut_wr[i]) if (dut_wr[i].a == 32'(r)) res = dut_wr[i].cyc;
    return res;
  endfunction

  task automatic load_rom(input bit rnd);
    for (int i = 0; i < 4096; i++) rom[i] = rnd ? rand_instr() : 32'd0;
    foreach (prog[i]) rom[i] = prog[i];
  endtask

  task automatic compare_log(input string tag, input ev_t got[$], input ev_t exp[$]);
    int bad0;
    check_value({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      bad0 = n_bad;
      check_value($sformatf("%s%0d_cyc", tag, i), got[i].cyc, exp[i].cyc);
      check_value($sformatf("%s%0d_addr", tag, i), got[i].a, exp[i].a);
      check_value($sformatf("%s%0d_data", tag, i), got[i].d, exp[i].d);
      if (n_bad != bad0) break;
    end
  endtask

  task automatic run_prog(input string name, input int n, input bit rnd, input int abort_cyc);
    int total;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) init_rf[i] = rnd ? $urandom : 32'd0;
    init_rf[0] = 32'd0;
    for (int i = 0; i < 4096; i++) init_mem[i] = rnd ? $urandom : 32'd0;
    m_regs = init_rf;
    m_mem = init_mem;
    exp_wr.delete();
    exp_sw.delete();
    model_run(n, total);
    repeat (2) @(negedge clock);
    check_value({name, "_rst_we"}, ctrl_writeEnable, 0);
    check_value({name, "_rst_wren"}, wren, 0);
    check_value({name, "_rst_pc"}, address_imem, 0);
    check_value({name, "_rst_wreg"}, ctrl_writeReg, 0);
    check_value({name, "_rst_wdata"}, data_writeReg, 0);
    check_value({name, "_rst_daddr"}, address_dmem, 0);
    check_value({name, "_rst_data"}, data, 0);
    reset = 1'b0;
    if (abort_cyc > 0) begin
      repeat (abort_cyc) @(negedge clock);
      check_value({name, "_pre_abort_wren"}, wren, 1);
      #2 reset = 1'b1;
      #1;
      check_value({name, "_abort_wren"}, wren, 0);
      check_value({name, "_abort_we"}, ctrl_writeEnable, 0);
      check_value({name, "_abort_pc"}, address_imem, 0);
      check_value({name, "_abort_daddr"}, address_dmem, 0);
      $display("prog %-8s aborted by reset at cycle %0d", name, abort_cyc);
      return;
    end
    repeat (total) @(negedge clock);
    check_value({name, "_pc"}, address_imem, m_pc_final);
    compare_log({name, "_wr"}, dut_wr, exp_wr);
    compare_log({name, "_sw"}, dut_sw, exp_sw);
    for (int r = 1; r < 32; r++) check_value($sformatf("%s_r%0d", name, r), rf[r], m_regs[r]);
    foreach (exp_sw[i])
      check_value($sformatf("%s_mem%0d", name, i), dram[exp_sw[i].a[11:0]], m_mem[exp_sw[i].a[11:0]]);
    $display("prog %-8s instr=%0d cycles=%0d writes=%0d stores=%0d pc=%h",
             name, n, total, dut_wr.size(), dut_sw.size(), address_imem);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 32; i++) init_rf[i] = 32'd0;
    for (int i = 0; i < 4096; i++) init_mem[i] = 32'd0;

    prog = '{enc_i(5, 1, 0, 5), enc_i(5, 2, 0, 7), enc_r(0, 3, 1, 2, 0)};
    load_rom(0);
    run_prog("p1", 3, 0, 0);
    check_value("p1_r1", rf[1], 5);
    check_value("p1_r2", rf[2], 7);
    check_value("p1_r3", rf[3], 12);
    check_value("p1_r3_cycle", last_wr_cyc(3), 5);

    prog = '{enc_i(5, 1, 0, -1), enc_r(4, 4, 1, 0, 4), enc_r(5, 5, 1, 0, 4)};
    load_rom(0);
    run_prog("p2", 3, 0, 0);
    check_value("p2_sll", rf[4], 32'hFFFF_FFF0);
    check_value("p2_sra", rf[5], 32'hFFFF_FFFF);

    prog = '{enc_i(5, 8, 0, 1), enc_r(4, 8, 8, 0, 31), enc_i(5, 7, 0, -1),
             enc_r(1, 1, 7, 8, 0), enc_r(0, 2, 1, 1, 0), enc_r(1, 2, 8, 1, 0)};
    load_rom(0);
    run_prog("p3a", 5, 0, 0);
    check_value("p3a_r1", rf[1], 32'h7FFF_FFFF);
    check_value("p3a_r2", rf[2], 0);
    check_value("p3a_r30", rf[30], 1);
    run_prog("p3b", 6, 0, 0);
    check_value("p3b_r2", rf[2], 0);
    check_value("p3b_r30", rf[30], 3);

    prog = '{enc_i(5, 1, 0, 42), enc_i(7, 1, 0, 3), enc_i(8, 2, 0, 3)};
    load_rom(0);
    run_prog("p4", 3, 0, 0);
    check_value("p4_ram3", dram[3], 42);
    check_value("p4_r2", rf[2], 42);
    check_value("p4_lw_cycle", last_wr_cyc(2), 6);
    check_value("p4_pc", address_imem, 3);

    prog = '{enc_i(5, 1, 0, 1), enc_i(5, 2, 0, 2), enc_i(2, 1, 2, 1), enc_i(5, 10, 0, 99),
             enc_i(6, 1, 2, 1), enc_i(5, 11, 0, 99), enc_j(3, 9), enc_i(5, 12, 0, 5),
             enc_j(1, 11), enc_i(4, 31, 0, 0), enc_i(5, 13, 0, 99), enc_j(21, 7),
             enc_j(22, 14), enc_i(5, 14, 0, 99), 32'd0};
    load_rom(0);
    run_prog("p5", 11, 0, 0);
    check_value("p5_bne_skip", rf[10], 0);
    check_value("p5_blt_skip", rf[11], 0);
    check_value("p5_jr_skip", rf[13], 0);
    check_value("p5_bex_skip", rf[14], 0);
    check_value("p5_r31", rf[31], 7);
    check_value("p5_r12", rf[12], 5);
    check_value("p5_r30", rf[30], 7);
    check_value("p5_pc", address_imem, 15);

    prog = '{enc_i(5, 1, 0, 42), enc_i(7, 1, 0, 3), enc_i(8, 2, 0, 3)};
    load_rom(0);
    run_prog("p6", 3, 0, 3);

    for (int t = 0; t < 20; t++) begin
      prog.delete();
      load_rom(1);
      run_prog($sformatf("rnd%0d", t), 40, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
